// File: rtl/imem_dmem_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch and data access.
// One transaction is in flight at a time, and the memory port is driven from registers.
module imem_dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack,
    output logic            err
);

    localparam int BW = DW / 8;
    localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

    state_e          state_q, state_d;
    logic            lastD_q, lastD_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            mReq_q, mReq_d;
    logic            mWe_q, mWe_d;
    logic [AW-1:0]   mAddr_q, mAddr_d;
    logic [DW-1:0]   mWdata_q, mWdata_d;
    logic [BW-1:0]   mBe_q, mBe_d;
    logic            iAck_q, iAck_d;
    logic            dAck_q, dAck_d;
    logic [DW-1:0]   iRdata_q, iRdata_d;
    logic [DW-1:0]   dRdata_q, dRdata_d;
    logic            err_q, err_d;
    logic            grantD;
    logic            timeout;

    assign timeout = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    // On a tie, the port that did not win last time gets the grant.
    assign grantD  = d_req && (!i_req || !lastD_q);

    always_comb begin
        state_d  = state_q;
        lastD_d  = lastD_q;
        cnt_d    = cnt_q;
        mReq_d   = mReq_q;
        mWe_d    = mWe_q;
        mAddr_d  = mAddr_q;
        mWdata_d = mWdata_q;
        mBe_d    = mBe_q;
        iAck_d   = 1'b0;
        dAck_d   = 1'b0;
        iRdata_d = iRdata_q;
        dRdata_d = dRdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (grantD) begin
                    state_d  = BUSY_D;
                    lastD_d  = 1'b1;
                    mReq_d   = 1'b1;
                    mWe_d    = d_we;
                    mAddr_d  = d_addr;
                    mWdata_d = d_wdata;
                    mBe_d    = d_be;
                end else if (i_req) begin
                    state_d  = BUSY_I;
                    lastD_d  = 1'b0;
                    mReq_d   = 1'b1;
                    mWe_d    = 1'b0;
                    mAddr_d  = i_addr;
                    mWdata_d = '0;
                    mBe_d    = '1;
                end
            end
            BUSY_I, BUSY_D: begin
                cnt_d = cnt_q + 1'b1;
                if (m_ack || timeout) begin
                    state_d = RESP;
                    mReq_d  = 1'b0;
                    cnt_d   = '0;
                    if (!m_ack) begin
                        err_d = 1'b1;
                    end
                    // A store leaves the load data register untouched; a timeout zeroes it.
                    if (state_q == BUSY_I) begin
                        iAck_d   = 1'b1;
                        iRdata_d = m_ack ? m_rdata : '0;
                    end else begin
                        dAck_d = 1'b1;
                        if (!m_ack) begin
                            dRdata_d = '0;
                        end else if (!mWe_q) begin
                            dRdata_d = m_rdata;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            lastD_q  <= 1'b0;
            cnt_q    <= '0;
            mReq_q   <= 1'b0;
            mWe_q    <= 1'b0;
            mAddr_q  <= '0;
            mWdata_q <= '0;
            mBe_q    <= '0;
            iAck_q   <= 1'b0;
            dAck_q   <= 1'b0;
            iRdata_q <= '0;
            dRdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lastD_q  <= lastD_d;
            cnt_q    <= cnt_d;
            mReq_q   <= mReq_d;
            mWe_q    <= mWe_d;
            mAddr_q  <= mAddr_d;
            mWdata_q <= mWdata_d;
            mBe_q    <= mBe_d;
            iAck_q   <= iAck_d;
            dAck_q   <= dAck_d;
            iRdata_q <= iRdata_d;
            dRdata_q <= dRdata_d;
            err_q    <= err_d;
        end
    end

    assign m_req   = mReq_q;
    assign m_we    = mWe_q;
    assign m_addr  = mAddr_q;
    assign m_wdata = mWdata_q;
    assign m_be    = mBe_q;
    assign i_ack   = iAck_q;
    assign d_ack   = dAck_q;
    assign i_rdata = iRdata_q;
    assign d_rdata = dRdata_q;
    assign err     = err_q;

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port memory between the pipeline's instruction-fetch port and data (load/store) port.
- Each port uses a req/ack handshake. The arbiter grants one transaction at a time and drives the shared memory port from registers.
- The arbiter returns read data and a one-cycle ack to the winner. The pipeline stalls on the missing ack.
- A watchdog terminates transactions the memory never acknowledges.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- TIMEOUT, 255, maximum BUSY cycles before forced termination; 0 disables the watchdog.
- TW, 8, watchdog counter width; must satisfy TIMEOUT < 2^TW.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr stable until i_ack.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetch data; valid when i_ack=1.
- i_ack  out  1  one-cycle fetch completion.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_be  in  DW/8  store byte enables.
- d_rdata  out  DW  load data; valid when d_ack=1.
- d_ack  out  1  one-cycle data completion.
- m_req  out  1  memory request; held until m_ack.
- m_we  out  1  memory write.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_be  out  DW/8  memory byte enables; all ones for fetches.
- m_rdata  in  DW  memory read data; valid with m_ack.
- m_ack  in  1  memory completion; sampled only while m_req=1.
- err  out  1  sticky watchdog error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; last_grant = I.
  - All outputs 0: m_req, m_we, m_addr, m_wdata, m_be, i_ack, d_ack, i_rdata, d_rdata, err.
  - Watchdog counter = 0.
  - Reset mid-transaction drops m_req immediately. No ack is issued for the aborted transaction.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - With only i_req: go to BUSY_I.
  - With only d_req: go to BUSY_D.
  - With both: grant the port not equal to last_grant, so D wins the first tie after reset; update last_grant.
  - On grant, register the m_* fields from the winner. A fetch drives m_we=0 and m_be=all ones. m_req=1 from the next cycle.
- BUSY_x:
  - m_req and all m_* fields are held constant.
  - Counter increments each cycle.
  - When m_ack=1: capture m_rdata into the winner's rdata register, go to RESP, drop m_req, clear the counter.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT with no m_ack: go to RESP, set err=1, rdata = 0.
- RESP:
  - Exactly one cycle. Winner's ack = 1 with its rdata; the other ack = 0.
  - Next state is IDLE unconditionally. This prevents re-granting a request still held during its ack cycle.
- rdata registers hold their value until the next completion on that port.
- A store returns ack with rdata unchanged from its previous value.
- Latency: request seen at edge N; m_req high during cycle N+1. With m_ack in the same cycle, ack is high in cycle N+2 and the arbiter is back in IDLE at N+3. Minimum 3 cycles per transaction.
- m_ack outside BUSY is ignored.
- Requests dropped before ack are a protocol violation. Behaviour is undefined, but the arbiter must still complete the memory transaction and return to IDLE.
- err clears only on reset.
- i_ack and d_ack are never high in the same cycle. At most one memory transaction is outstanding.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, memory acks 1 cycle after m_req with 0x00500093 -> m_addr=0x100, m_we=0, m_be=0xF; i_ack pulses once with i_rdata=0x00500093; d_ack stays 0.
- Store: d_req, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=0x3, zero-wait memory -> m_* match exactly; d_ack is high exactly 2 cycles after the req-seen edge.
- Contention: i_req and d_req both high from reset release -> data served first, fetch second; continued contention alternates D, I, D, I.
- Variable latency: m_ack delayed 5 cycles -> m_req and m_addr held stable all 5 cycles; single ack pulse; no re-grant in the RESP cycle.
- Watchdog: TIMEOUT=4, m_ack never asserted -> ack after 4 BUSY cycles; rdata=0; err=1 and stays 1 through later good transactions.
- Reset mid-transaction: reset=0 asserted in BUSY_D -> m_req=0 asynchronously; no d_ack; after release the first contention again grants D.
